// File: rtl/freq_meter_if.sv
// Measurement bus of the frequency meter: the square-wave input and the
// reported frequency with its status strobes.
interface freq_meter_if;
    logic        sigIn;
    logic [19:0] freq;
    logic        valid;
    logic        timeout;
    logic        overrun;

    modport master (output sigIn, input freq, valid, timeout, overrun);
    modport slave  (input sigIn, output freq, valid, timeout, overrun);
endinterface

// File: rtl/freq_meter.sv
// Measures the period of an asynchronous square wave in inClock cycles and
// reports BASE_SPEED / period in whole Hz via a 32-step restoring divider.
module freq_meter #(
    parameter int unsigned BASE_SPEED = 25000000,
    parameter int unsigned MIN_FREQ   = 1
) (
    input  logic         inClock,
    input  logic         reset,
    freq_meter_if.slave  bus
);
    localparam logic [31:0] TLIM     = 32'(BASE_SPEED / MIN_FREQ);
    localparam logic [31:0] DIVIDEND = 32'(BASE_SPEED);
    localparam logic [31:0] FREQ_MAX = 32'h000F_FFFF;

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, DONE} state_t;

    state_t      state;
    logic        s1, s2, s3;
    logic        edge_det;
    logic [31:0] cnt;
    logic [31:0] divisor;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [4:0]  iter;
    logic [32:0] trial;
    logic [31:0] diff;
    logic        qbit;
    logic [19:0] freq_q;
    logic        valid_q, timeout_q, overrun_q;

    assign edge_det = s2 & ~s3;

    // quot starts as the dividend and is shifted out MSB first while the
    // quotient bits shift in, so it holds the quotient after 32 steps.
    // rem < divisor always, so the subtraction result fits in 32 bits.
    assign trial = {rem, quot[31]};
    assign qbit  = (trial >= {1'b0, divisor});
    assign diff  = trial[31:0] - divisor;

    assign bus.freq    = freq_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;
    assign bus.overrun = overrun_q;

    always_ff @(posedge inClock) begin
        if (reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s3  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= bus.sigIn;
            s2 <= s1;
            s3 <= s2;
            if (edge_det)
                cnt <= 32'd1;
            else if (cnt != TLIM)
                cnt <= cnt + 32'd1;
        end
    end

    always_ff @(posedge inClock) begin
        if (reset) begin
            state     <= IDLE;
            divisor   <= '0;
            quot      <= '0;
            rem       <= '0;
            iter      <= '0;
            freq_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (edge_det)
                        state <= MEASURE;
                end
                MEASURE: begin
                    if (edge_det) begin
                        divisor <= cnt;
                        quot    <= DIVIDEND;
                        rem     <= '0;
                        iter    <= '0;
                        state   <= DIVIDE;
                    end else if (cnt == TLIM) begin
                        freq_q    <= '0;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DIVIDE: begin
                    // A new edge abandons the running divide and restarts on
                    // the freshly captured period.
                    if (edge_det) begin
                        divisor   <= cnt;
                        quot      <= DIVIDEND;
                        rem       <= '0;
                        iter      <= '0;
                        overrun_q <= 1'b1;
                    end else begin
                        rem  <= qbit ? diff : trial[31:0];
                        quot <= {quot[30:0], qbit};
                        iter <= iter + 5'd1;
                        if (iter == 5'd31)
                            state <= DONE;
                    end
                end
                DONE: begin
                    freq_q    <= (quot > FREQ_MAX) ? 20'hFFFFF : quot[19:0];
                    valid_q   <= 1'b1;
                    timeout_q <= 1'b0;
                    if (edge_det) begin
                        divisor <= cnt;
                        quot    <= DIVIDEND;
                        rem     <= '0;
                        iter    <= '0;
                        state   <= DIVIDE;
                    end else begin
                        state <= MEASURE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// Randomized and directed bench for freq_meter; expected results come from a
// rise-time/gap model of the measurement rules.
module tb_freq_meter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sa = 1'b0, sb = 1'b0, sc = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    freq_meter_if ifa ();
    freq_meter_if ifb ();
    freq_meter_if ifc ();
    assign ifa.sigIn = sa;
    assign ifb.sigIn = sb;
    assign ifc.sigIn = sc;

    freq_meter #(.BASE_SPEED(25000000), .MIN_FREQ(1000)) dut_a (.inClock(clk), .reset(rst), .bus(ifa));
    freq_meter #(.BASE_SPEED(100),      .MIN_FREQ(1))    dut_b (.inClock(clk), .reset(rst), .bus(ifb));
    freq_meter #(.BASE_SPEED(50000000), .MIN_FREQ(1))    dut_c (.inClock(clk), .reset(rst), .bus(ifc));

    typedef struct { int cyc; int f; bit to; } ev_t;
    ev_t eva[$];
    ev_t evb[$];
    ev_t exp_q[$];
    ev_t mon_e;
    int  ovra = 0, ovrb = 0;
    int  exp_ovr;
    int  rises[$];

    // Every valid pulse is logged with the cycle it was seen in.
    always @(negedge clk) begin
        if (ifa.valid) begin
            mon_e.cyc = cyc; mon_e.f = int'(ifa.freq); mon_e.to = ifa.timeout;
            eva.push_back(mon_e);
        end
        if (ifb.valid) begin
            mon_e.cyc = cyc; mon_e.f = int'(ifb.freq); mon_e.to = ifb.timeout;
            evb.push_back(mon_e);
        end
        if (ifa.overrun) ovra++;
        if (ifb.overrun) ovrb++;
    end

    function automatic int sat_q(input longint b, input int p);
        longint q;
        q = b / p;
        return (q > 1048575) ? 1048575 : int'(q);
    endfunction

    // First rise arms; every later rise measures the gap before it. That
    // measurement reports 34 cycles after its edge (36 after the rise) unless
    // the next rise follows within 33 cycles, which discards it.
    function automatic void build_model(input longint base);
        int p;
        ev_t e;
        exp_q.delete();
        exp_ovr = 0;
        for (int i = 1; i < rises.size(); i++) begin
            p = rises[i] - rises[i-1];
            if (i + 1 < rises.size() && rises[i+1] - rises[i] < 33)
                exp_ovr++;
            else begin
                e.cyc = rises[i] + 36; e.f = sat_q(base, p); e.to = 1'b0;
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic set_sig(input int which, input logic v);
        case (which)
            0: sa = v;
            1: sb = v;
            default: sc = v;
        endcase
    endtask

    // Rise now, stay high h cycles, return gap cycles after the rise.
    task automatic pulse(input int which, input int gap, input int h);
        set_sig(which, 1'b1);
        rises.push_back(cyc);
        repeat (h) @(negedge clk);
        set_sig(which, 1'b0);
        repeat (gap - h) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sa = 1'b0; sb = 1'b0; sc = 1'b0;
        rises.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({ifa.freq, ifa.valid, ifa.timeout, ifa.overrun} !== 23'd0) begin
            n_bad++; $display("FAIL reset_a: got freq=%0d v=%b t=%b o=%b want all zero", ifa.freq, ifa.valid, ifa.timeout, ifa.overrun);
        end
        n_cmp++;
        if ({ifb.freq, ifb.valid, ifb.timeout, ifb.overrun} !== 23'd0) begin
            n_bad++; $display("FAIL reset_b: got freq=%0d v=%b t=%b o=%b want all zero", ifb.freq, ifb.valid, ifb.timeout, ifb.overrun);
        end
    endtask

    task automatic test_steady();
        int g[6] = '{2500, 2500, 568, 568, 1136, 100};
        int a0, o0;
        do_reset();
        a0 = eva.size(); o0 = ovra;
        foreach (g[i]) pulse(0, g[i], g[i] / 2);
        build_model(25000000);
        n_cmp++;
        if (eva.size() - a0 !== exp_q.size()) begin
            n_bad++; $display("FAIL steady_count: got %0d want %0d", eva.size() - a0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && a0 + i < eva.size(); i++) begin
            n_cmp++;
            if (eva[a0+i].cyc !== exp_q[i].cyc || eva[a0+i].f !== exp_q[i].f || eva[a0+i].to !== exp_q[i].to) begin
                n_bad++; $display("FAIL steady_ev%0d: got cyc=%0d f=%0d to=%b want cyc=%0d f=%0d to=%b", i,
                    eva[a0+i].cyc, eva[a0+i].f, eva[a0+i].to, exp_q[i].cyc, exp_q[i].f, exp_q[i].to);
            end
        end
        n_cmp++;
        if (ovra - o0 !== exp_ovr) begin
            n_bad++; $display("FAIL steady_overrun: got %0d want %0d", ovra - o0, exp_ovr);
        end
    endtask

    task automatic test_overrun();
        int a0, o0;
        do_reset();
        a0 = eva.size(); o0 = ovra;
        repeat (8) pulse(0, 10, 5);
        n_cmp++;
        if (eva.size() !== a0 || ifa.freq !== 20'd0) begin
            n_bad++; $display("FAIL overrun_hold: got valids=%0d freq=%0d want 0 and 0", eva.size() - a0, ifa.freq);
        end
        repeat (3) pulse(0, 40, 5);
        pulse(0, 100, 5);
        build_model(25000000);
        n_cmp++;
        if (eva.size() - a0 !== exp_q.size()) begin
            n_bad++; $display("FAIL overrun_count: got %0d want %0d", eva.size() - a0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && a0 + i < eva.size(); i++) begin
            n_cmp++;
            if (eva[a0+i].cyc !== exp_q[i].cyc || eva[a0+i].f !== exp_q[i].f || eva[a0+i].to !== exp_q[i].to) begin
                n_bad++; $display("FAIL overrun_ev%0d: got cyc=%0d f=%0d to=%b want cyc=%0d f=%0d to=%b", i,
                    eva[a0+i].cyc, eva[a0+i].f, eva[a0+i].to, exp_q[i].cyc, exp_q[i].f, exp_q[i].to);
            end
        end
        n_cmp++;
        if (ovra - o0 !== exp_ovr) begin
            n_bad++; $display("FAIL overrun_pulses: got %0d want %0d", ovra - o0, exp_ovr);
        end
    endtask

    // Gap 33 lands on the DONE cycle, gap 32 on the last divide step.
    task automatic test_done_edge();
        int g[6] = '{2000, 33, 500, 32, 500, 100};
        int a0, o0;
        do_reset();
        a0 = eva.size(); o0 = ovra;
        foreach (g[i]) pulse(0, g[i], g[i] / 2);
        build_model(25000000);
        n_cmp++;
        if (eva.size() - a0 !== exp_q.size()) begin
            n_bad++; $display("FAIL done_edge_count: got %0d want %0d", eva.size() - a0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && a0 + i < eva.size(); i++) begin
            n_cmp++;
            if (eva[a0+i].cyc !== exp_q[i].cyc || eva[a0+i].f !== exp_q[i].f) begin
                n_bad++; $display("FAIL done_edge_ev%0d: got cyc=%0d f=%0d want cyc=%0d f=%0d", i,
                    eva[a0+i].cyc, eva[a0+i].f, exp_q[i].cyc, exp_q[i].f);
            end
        end
        n_cmp++;
        if (ovra - o0 !== exp_ovr) begin
            n_bad++; $display("FAIL done_edge_overrun: got %0d want %0d", ovra - o0, exp_ovr);
        end
    endtask

    task automatic test_random();
        int a0, o0, gap;
        do_reset();
        a0 = eva.size(); o0 = ovra;
        for (int k = 0; k < 14; k++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 31)) : int'($urandom_range(34, 1500));
            pulse(0, gap, int'($urandom_range(1, gap - 1)));
        end
        pulse(0, 100, 50);
        build_model(25000000);
        n_cmp++;
        if (eva.size() - a0 !== exp_q.size()) begin
            n_bad++; $display("FAIL random_count: got %0d want %0d", eva.size() - a0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && a0 + i < eva.size(); i++) begin
            n_cmp++;
            if (eva[a0+i].cyc !== exp_q[i].cyc || eva[a0+i].f !== exp_q[i].f || eva[a0+i].to !== exp_q[i].to) begin
                n_bad++; $display("FAIL random_ev%0d: got cyc=%0d f=%0d to=%b want cyc=%0d f=%0d to=%b", i,
                    eva[a0+i].cyc, eva[a0+i].f, eva[a0+i].to, exp_q[i].cyc, exp_q[i].f, exp_q[i].to);
            end
        end
        n_cmp++;
        if (ovra - o0 !== exp_ovr) begin
            n_bad++; $display("FAIL random_overrun: got %0d want %0d", ovra - o0, exp_ovr);
        end
    endtask

    task automatic test_reset_mid();
        int a0;
        do_reset();
        pulse(0, 500, 250);
        pulse(0, 500, 250);
        n_cmp++;
        if (ifa.freq !== 20'd50000) begin
            n_bad++; $display("FAIL midrst_pre: got freq=%0d want 50000", ifa.freq);
        end
        // Third rise starts a divide; its step 15 runs 18 cycles after the rise.
        pulse(0, 18, 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({ifa.freq, ifa.valid, ifa.timeout, ifa.overrun} !== 23'd0) begin
            n_bad++; $display("FAIL midrst_clear: got freq=%0d v=%b t=%b o=%b want all zero", ifa.freq, ifa.valid, ifa.timeout, ifa.overrun);
        end
        rises.delete();
        a0 = eva.size();
        pulse(0, 300, 150);
        pulse(0, 300, 150);
        pulse(0, 100, 50);
        build_model(25000000);
        n_cmp++;
        if (eva.size() - a0 !== exp_q.size()) begin
            n_bad++; $display("FAIL midrst_count: got %0d want %0d", eva.size() - a0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && a0 + i < eva.size(); i++) begin
            n_cmp++;
            if (eva[a0+i].cyc !== exp_q[i].cyc || eva[a0+i].f !== exp_q[i].f) begin
                n_bad++; $display("FAIL midrst_ev%0d: got cyc=%0d f=%0d want cyc=%0d f=%0d", i,
                    eva[a0+i].cyc, eva[a0+i].f, exp_q[i].cyc, exp_q[i].f);
            end
        end
    endtask

    // BASE_SPEED=100, TLIM=100: edge coinciding with TLIM, P=2, then timeout.
    task automatic test_timeout();
        int b0, o0;
        ev_t e;
        do_reset();
        b0 = evb.size(); o0 = ovrb;
        pulse(1, 100, 50);
        pulse(1, 40, 20);
        pulse(1, 2, 1);
        pulse(1, 150, 1);
        exp_q.delete();
        e.cyc = rises[1] + 36;  e.f = 100 / 100; e.to = 1'b0; exp_q.push_back(e);
        e.cyc = rises[3] + 36;  e.f = 100 / 2;   e.to = 1'b0; exp_q.push_back(e);
        e.cyc = rises[3] + 103; e.f = 0;         e.to = 1'b1; exp_q.push_back(e);
        n_cmp++;
        if (ifb.timeout !== 1'b1) begin
            n_bad++; $display("FAIL timeout_level: got %b want 1", ifb.timeout);
        end
        // First edge after a timeout only re-arms.
        pulse(1, 60, 30);
        n_cmp++;
        if (ifb.timeout !== 1'b1 || evb.size() - b0 !== 3) begin
            n_bad++; $display("FAIL timeout_rearm: got to=%b valids=%0d want 1 and 3", ifb.timeout, evb.size() - b0);
        end
        pulse(1, 60, 30);
        e.cyc = rises[5] + 36; e.f = 100 / 60; e.to = 1'b0; exp_q.push_back(e);
        n_cmp++;
        if (evb.size() - b0 !== exp_q.size()) begin
            n_bad++; $display("FAIL timeout_count: got %0d want %0d", evb.size() - b0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && b0 + i < evb.size(); i++) begin
            n_cmp++;
            if (evb[b0+i].cyc !== exp_q[i].cyc || evb[b0+i].f !== exp_q[i].f || evb[b0+i].to !== exp_q[i].to) begin
                n_bad++; $display("FAIL timeout_ev%0d: got cyc=%0d f=%0d to=%b want cyc=%0d f=%0d to=%b", i,
                    evb[b0+i].cyc, evb[b0+i].f, evb[b0+i].to, exp_q[i].cyc, exp_q[i].f, exp_q[i].to);
            end
        end
        n_cmp++;
        if (ovrb - o0 !== 1) begin
            n_bad++; $display("FAIL timeout_overrun: got %0d want 1", ovrb - o0);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        pulse(2, 40, 5);
        pulse(2, 60, 5);
        n_cmp++;
        if (int'(ifc.freq) !== sat_q(50000000, 40)) begin
            n_bad++; $display("FAIL saturate: got freq=%0d want %0d", ifc.freq, sat_q(50000000, 40));
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_overrun();
        test_done_edge();
        test_random();
        test_reset_mid();
        test_timeout();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
